// File: rtl/if_id_pkg.sv
// if_id_pkg: shared types and constants for the IF/ID decoupling queue.
package if_id_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } if_id_entry_t;

    localparam logic [31:0] IF_ID_NOP = 32'b0;
    localparam int IF_ID_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/if_id_entry_mem.sv
// if_id_entry_mem: DEPTH-entry register array, one write port, asynchronous read.
module if_id_entry_mem
    import if_id_pkg::*;
#(
    parameter int DEPTH = IF_ID_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_addr,
    input  if_id_entry_t       wr_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output if_id_entry_t       rd_data
);

    if_id_entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            mem <= '{default: '0};
        else if (wr_en)
            mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order fetch-to-decode buffer with registered freeze and branch flush.
// Define IF_ID_QUEUE_STATS_EN to add the stall_cycles / flush_count counters.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH = IF_ID_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        branch_taken,
    output logic        freeze,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    input  logic        id_ready
`ifdef IF_ID_QUEUE_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, push, pop;
    if_id_entry_t     wr_data, head;

    // freeze sees only registered count and branch_taken, never id_ready
    assign full     = count == (PTR_W+1)'(DEPTH);
    assign freeze   = full & ~branch_taken;
    assign push     = ~freeze & ~branch_taken;
    assign id_valid = count != '0;
    assign pop      = id_valid & id_ready & ~branch_taken;
    assign wr_data  = '{pc: if_pc, instruction: if_instruction};

    if_id_entry_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst || branch_taken) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end

    assign id_pc          = id_valid ? head.pc : IF_ID_NOP;
    assign id_instruction = id_valid ? head.instruction : IF_ID_NOP;

`ifdef IF_ID_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (freeze && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (branch_taken && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized scoreboard bench with a queue-based reference model and fetch model.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instruction = '0;
    logic        branch_taken = 1'b0;
    logic        freeze, id_valid;
    logic [31:0] id_pc, id_instruction;
    logic        id_ready = 1'b0;
`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .branch_taken   (branch_taken),
        .freeze         (freeze),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_ready       (id_ready)
`ifdef IF_ID_QUEUE_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    if_id_entry_t mq[$];
    if_id_entry_t sb[$];
    logic [31:0] fpc = '0;
    int stall_m = 0;
    int flush_m = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        return (pc == 32'd24) ? 32'h01A2_0000 : (pc * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    // monitor: compares whatever the DUT presents against the scoreboard head
    always @(negedge clk)
        if (mon_en && rst) begin
            if (id_valid) begin
                if (sb.size() == 0)
                    chk("sb_underflow_valid", id_valid, 1'b0);
                else begin
                    chk("id_pc", id_pc, sb[0].pc);
                    chk("id_instruction", id_instruction, sb[0].instruction);
                    if (id_ready && !branch_taken)
                        void'(sb.pop_front());
                end
            end else begin
                chk("nop_pc", id_pc, IF_ID_NOP);
                chk("nop_instruction", id_instruction, IF_ID_NOP);
            end
        end

    // one clock: drive inputs, check control outputs, then advance the model and fetch
    task automatic step(input logic rdy, input logic bt, input logic [31:0] tgt);
        logic exp_freeze, exp_valid;
        if_id_entry_t e;
        id_ready       = rdy;
        branch_taken   = bt;
        if_pc          = fpc;
        if_instruction = instr_at(fpc);
        e = '{pc: fpc, instruction: instr_at(fpc)};
        exp_freeze = (mq.size() == DEPTH) && !bt;
        exp_valid  = mq.size() != 0;
        @(negedge clk);
        chk("freeze", freeze, exp_freeze);
        chk("id_valid", id_valid, exp_valid);
        @(posedge clk);
        if (exp_freeze) stall_m++;
        if (bt) begin
            flush_m++;
            mq.delete();
            sb.delete();
            fpc = tgt;
        end else begin
            if (exp_valid && rdy)
                void'(mq.pop_front());
            if (!exp_freeze) begin
                mq.push_back(e);
                sb.push_back(e);
                fpc = fpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_freeze", freeze, 1'b0);
        chk("rst_id_pc", id_pc, 32'h0);
        mq.delete();
        sb.delete();
        fpc = '0;
        stall_m = 0;
        flush_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_id_valid", id_valid, 1'b0);
        chk("reset_freeze", freeze, 1'b0);
        chk("reset_id_instruction", id_instruction, 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        // free-flowing stream 0,4,8,12
        repeat (5) step(1'b1, 1'b0, 32'h0);
        // decode stall then release
        reset_pulse();
        repeat (4) step(1'b0, 1'b0, 32'h0);
        chk("held_fetch_pc", fpc, 32'd8);
        repeat (4) step(1'b1, 1'b0, 32'h0);
        // queue holding 4,8 then branch to 24
        reset_pulse();
        repeat (2) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'd24);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        // full queue flushed while decode stalls
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'd100);
        chk("branch_fetch_pc", fpc, 32'd100);
        step(1'b1, 1'b0, 32'h0);
        // reset while full
        repeat (3) step(1'b0, 1'b0, 32'h0);
        reset_pulse();
        repeat (4) step(1'b1, 1'b0, 32'h0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699)
                reset_pulse();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 32'($urandom_range(0, 63)) * 32'd4);
        end
`ifdef IF_ID_QUEUE_STATS_EN
        reset_pulse();
        repeat (2) step(1'b0, 1'b0, 32'h0);
        repeat (5) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'd40);
        step(1'b1, 1'b1, 32'd80);
        chk("stall_cycles", stall_cycles, 32'(stall_m));
        chk("flush_count", {16'h0, flush_count}, 32'(flush_m));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling buffer on the consumer side of the instruction-fetch interface. Captures the fetch stage's `PC`/`Instruction` pair every cycle the fetch stage advances and presents entries in order to the decode stage under a valid/ready handshake. Drives the fetch stage's `freeze` input from registered occupancy, so decode back-pressure never forms a combinational path into the PC register. A branch-taken flush discards all queued and in-flight wrong-path instructions.

## Interface

Parameters:
- `DEPTH`, 2: entry count; power of two, minimum 2.
- `PTR_W`, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_pc` in 32: PC of the instruction currently presented by fetch.
- `if_instruction` in 32: instruction at `if_pc`.
- `branch_taken` in 1: flush request; same signal that drives fetch's branch select.
- `freeze` out 1: to fetch; holds the PC register when 1.
- `id_valid` out 1: head entry valid.
- `id_pc` out 32: head entry PC.
- `id_instruction` out 32: head entry instruction.
- `id_ready` in 1: decode accepts the head this cycle.
- `stall_cycles` out 32: present only with `IF_ID_QUEUE_STATS_EN`.
- `flush_count` out 16: present only with `IF_ID_QUEUE_STATS_EN`.

## Operation

- State: entry array `DEPTH`×64 bits (pc, instruction), `wr_ptr`, `rd_ptr`, `count` (PTR_W+1 bits).
- Derived signals:
  - `full` = (count == DEPTH).
  - `freeze` = full & ~branch_taken.
  - `push` = ~freeze & ~branch_taken.
  - `pop` = id_valid & id_ready & ~branch_taken.
- Push: writes {if_pc, if_instruction} at `wr_ptr`; `wr_ptr` increments and wraps modulo DEPTH.
- Pop: `rd_ptr` increments and wraps modulo DEPTH.
- Push and pop in the same cycle: `count` is unchanged.
- Flush (`branch_taken`=1):
  - Highest priority. Next cycle `count`=0 and `rd_ptr`=`wr_ptr`=0.
  - The fetch word presented in the flush cycle is not captured.
  - `freeze` is forced 0 so fetch loads the branch target.
- `id_valid` = (count != 0).
- `id_pc`/`id_instruction` = head entry when valid; 32'b0 (NOP) when empty.
- Full with `id_ready`=1: pop occurs, no push, and `freeze` stays 1 that cycle. The next cycle resumes pushing. This bubble appears only after a decode stall.

## Timing

- Reset (rst=0, asynchronous): count, pointers and storage cleared; `id_valid`=0, `id_pc`=0, `id_instruction`=0, `freeze`=0; stats counters 0. Fetch resets PC to 0 synchronously, so the first captured entry after release is pc=0.
- Latency: word pushed at edge N is visible on `id_*` after edge N if the queue was empty. One cycle minimum from fetch to decode.
- `freeze` depends combinationally only on registered `count` and on `branch_taken`. There is no path from `id_ready`.
- Reset asserted mid-operation discards all entries immediately; no partial state survives.
- `branch_taken` with `id_ready`=1 in the same cycle: no pop is counted, and the head is discarded with the rest.

## Configuration

- `IF_ID_QUEUE_STATS_EN` defined: `stall_cycles` counts cycles with `freeze`=1, saturating at 32'hFFFF_FFFF. `flush_count` counts cycles with `branch_taken`=1, saturating at 16'hFFFF. Both are cleared only by reset.
- Undefined: both ports and counters are absent; functional behaviour is identical.

## Structure

- Shared package `if_id_pkg`: `if_id_entry_t` (pc[31:0], instruction[31:0]), `IF_ID_NOP` = 32'b0, `IF_ID_DEPTH_DEFAULT` = 2.
- One sub-module, `if_id_entry_mem`: DEPTH-entry register array with write port (en, addr, data) and asynchronous read port. Pointer and count control stays in the top.

## Test plan

- Reset release, `id_ready`=1 constant: `id_pc` sequence 0,4,8,12 on consecutive cycles; `freeze` never 1.
- `id_ready`=0 from the first push: `freeze`=1 after two pushes (pc 0,4) and fetch holds at 8. Raising `id_ready` yields 0,4,8 with no loss or duplicate.
- Queue holding pc 4,8, `branch_taken`=1 with BranchAddr=24: next cycle `id_valid`=0, then `id_pc`=24, `id_instruction`=32'h01A2_0000.
- Full queue with `branch_taken`=1 and `id_ready`=0: `freeze`=0 that cycle; queue empty next cycle; fetch PC=branch target.
- `rst` pulsed low mid-cycle while full: `id_valid`, `freeze` and `id_pc` go 0 before the next edge. Stream restarts at pc=0.
- With `IF_ID_QUEUE_STATS_EN`: 5 stalled cycles plus 2 flushes give `stall_cycles`=5 and `flush_count`=2.
